scaled_timer: RTL and testbench
===============================

SCALED_TIMER -- requirements
Module: scaled_timer

Interface
REQ-001 Parameter WIDTH, default 12: bit width of end_value and timer_value.
REQ-002 Parameter CLKS_PER_MS, default 50000: clk cycles per millisecond at 1x speed (50 MHz clock).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  count permitted when high; low pauses the timer.
REQ-006 restart  input  1  synchronous restart: latch configuration, clear prescaler, reload count.
REQ-007 difficulty  input  2  speed select; 0=1x, 1=2x, 2=3x, 3=4x.
REQ-008 mode_down  input  1  0 = count up from 0 to end_value; 1 = count down from end_value to 0; sampled at restart.
REQ-009 auto_reload  input  1  1 = reload and continue after each terminal count; sampled at restart.
REQ-010 end_value  input  WIDTH  terminal/start value in ms; sampled at restart only.
REQ-011 timer_value  output  WIDTH  current count in ms.
REQ-012 end_reached  output  1  high while state is DONE (sticky until restart or reset).
REQ-013 end_pulse  output  1  one-cycle strobe each time terminal count is reached.
REQ-014 running  output  1  high while state is RUN.

Function
REQ-015 State machine SHALL have states IDLE, RUN, PAUSED, DONE.
REQ-016 restart (any state) SHALL go to RUN if enable=1 else PAUSED, load timer_value to 0 (up) or latched end_value (down), clear prescaler; restart takes priority over all other events in the same cycle.
REQ-017 RUN with enable=0 SHALL go to PAUSED next cycle; PAUSED with enable=1 SHALL go to RUN; prescaler count SHALL hold while paused.
REQ-018 Tick period SHALL be CLKS_PER_MS / (difficulty+1), integer truncation, minimum 1 cycle.
REQ-019 In RUN the prescaler SHALL fire a tick when its count >= period-1 and then clear; a difficulty change SHALL take effect immediately, a shortened period firing on the next cycle if already exceeded.
REQ-020 Each tick SHALL increment (up) or decrement (down) timer_value by exactly 1; timer_value SHALL never pass the terminal value.
REQ-021 On the clock edge where timer_value becomes terminal, end_pulse SHALL be high for that following cycle, registered together with timer_value.
REQ-022 auto_reload=0: terminal count SHALL move to DONE; timer_value holds terminal value; end_reached high; no further ticks until restart.
REQ-023 auto_reload=1: state stays RUN; on the next tick after terminal, timer_value SHALL reload to its start value; end_reached stays low; end_pulse repeats each period.
REQ-024 Latched end_value=0 SHALL reach terminal on the first cycle after restart: end_pulse=1 once, DONE (or, with auto_reload, one pulse per tick).
REQ-025 Changing end_value, mode_down or auto_reload outside restart SHALL have no effect on the current run.
REQ-026 end_pulse SHALL never be high in two consecutive cycles.

Reset
REQ-027 reset asserted SHALL immediately force state IDLE, timer_value=0, end_reached=0, end_pulse=0, running=0, prescaler=0, latched config=0.
REQ-028 IDLE SHALL leave only on restart; enable alone SHALL not start counting.
REQ-029 reset asserted mid-run SHALL abort the run with no end_pulse emitted.

Structure
REQ-030 Shared package timer_pkg SHALL hold the state enumeration, difficulty encoding constants, and the tick-period function.
REQ-031 Prescaler SHALL be a separate sub-module ms_prescaler (inputs clk, reset, clear, enable, period; output tick).
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (bench uses CLKS_PER_MS=10, WIDTH=12, 20 ns clock)
REQ-033 Up, difficulty=0, end_value=100, restart, enable=1 -> timer_value=100 after 1000 cycles, end_pulse once, end_reached=1, value holds for 200 more cycles.
REQ-034 difficulty=1 and 2, end_value=100 -> terminal after 500 and 300 cycles (period 5, 3) respectively.
REQ-035 Down, end_value=20, auto_reload=1 -> 0 after 200 cycles, reload to 20 one tick later, end_pulse every 210 cycles, end_reached stays 0.
REQ-036 enable low for 37 cycles mid-run -> terminal delayed by exactly 37 cycles; running=0 while paused.
REQ-037 end_value=0 restart -> end_pulse on the next cycle, DONE; restart and reset together -> reset wins, all outputs 0.
REQ-038 reset asserted at timer_value=50 -> asynchronous clear of all outputs; stays IDLE despite enable=1 until restart.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, difficulty codes and tick-period helper
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_e;

    localparam logic [1:0] DIFF_1X = 2'd0;
    localparam logic [1:0] DIFF_2X = 2'd1;
    localparam logic [1:0] DIFF_3X = 2'd2;
    localparam logic [1:0] DIFF_4X = 2'd3;

    // Clock cycles per tick at the selected speed; never shorter than one cycle.
    function automatic int unsigned tick_period(input int unsigned clks_per_ms,
                                                input logic [1:0]  difficulty);
        int unsigned p;
        p = clks_per_ms / (32'(difficulty) + 32'd1);
        if (p == 32'd0) begin
            p = 32'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// rtl/ms_prescaler.sv - millisecond prescaler producing one tick per period
module ms_prescaler #(
    parameter int unsigned PW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    // Fire as soon as the count reaches the (possibly just shortened) period;
    // clear has priority so a restart never produces a stray tick.
    assign tick = enable && !clear && (32'(count_q) >= (period - 32'd1));

    // Next count: clear, wrap on tick, advance while enabled, hold otherwise.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + PW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scaled_timer.sv
// rtl/scaled_timer.sv - millisecond up/down timer with speed select and auto-reload
module scaled_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned CLKS_PER_MS = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [1:0]       difficulty,
    input  logic             mode_down,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] end_value,
    output logic [WIDTH-1:0] timer_value,
    output logic             end_reached,
    output logic             end_pulse,
    output logic             running
);

    localparam int unsigned PW = $clog2(CLKS_PER_MS + 1);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             down_q, down_d;
    logic             auto_q, auto_d;
    logic             zero_pend_q, zero_pend_d;
    logic             pulse_q, pulse_d;
    logic             reached_q, reached_d;
    logic             running_q, running_d;

    logic             tick;
    logic [31:0]      period;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_val;
    logic             hit;

    assign period    = tick_period(CLKS_PER_MS, difficulty);
    assign start_val = down_q ? end_q : '0;
    assign term_val  = down_q ? '0 : end_q;
    assign step_val  = down_q ? (timer_q - WIDTH'(1)) : (timer_q + WIDTH'(1));

    ms_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (restart),
        .enable (state_q == ST_RUN),
        .period (period),
        .tick   (tick)
    );

    // Next-state, counter and strobe logic; restart overrides everything.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        end_d       = end_q;
        down_d      = down_q;
        auto_d      = auto_q;
        zero_pend_d = zero_pend_q;
        hit         = 1'b0;

        if (restart) begin
            end_d       = end_value;
            down_d      = mode_down;
            auto_d      = auto_reload;
            timer_d     = mode_down ? end_value : '0;
            zero_pend_d = (end_value == '0);
            state_d     = enable ? ST_RUN : ST_PAUSED;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    state_d = enable ? ST_RUN : ST_PAUSED;
                    if (zero_pend_q) begin
                        // Zero-length run is already terminal at load time.
                        zero_pend_d = 1'b0;
                        hit         = 1'b1;
                    end else if (tick) begin
                        if (timer_q == term_val) begin
                            // Only reachable with auto-reload: start the next lap.
                            timer_d = start_val;
                            hit     = (start_val == term_val);
                        end else begin
                            timer_d = step_val;
                            hit     = (step_val == term_val);
                        end
                    end
                    if (hit && !auto_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_PAUSED: begin
                    state_d = enable ? ST_RUN : ST_PAUSED;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A one-cycle period could otherwise strobe back to back.
        pulse_d   = hit && !pulse_q;
        running_d = (state_d == ST_RUN);
        reached_d = (state_d == ST_DONE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            end_q       <= '0;
            down_q      <= 1'b0;
            auto_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            pulse_q     <= 1'b0;
            reached_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            end_q       <= end_d;
            down_q      <= down_d;
            auto_q      <= auto_d;
            zero_pend_q <= zero_pend_d;
            pulse_q     <= pulse_d;
            reached_q   <= reached_d;
            running_q   <= running_d;
        end
    end

    assign timer_value = timer_q;
    assign end_pulse   = pulse_q;
    assign end_reached = reached_q;
    assign running     = running_q;

endmodule

// File: tb/tb_scaled_timer.sv
// tb/tb_scaled_timer.sv - scoreboard bench for scaled_timer
module tb_scaled_timer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        restart;
    logic [1:0]  difficulty;
    logic        mode_down;
    logic        auto_reload;
    logic [11:0] end_value;
    logic [11:0] timer_value;
    logic        end_reached;
    logic        end_pulse;
    logic        running;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    logic prev_pulse = 1'b0;

    scaled_timer #(
        .WIDTH       (12),
        .CLKS_PER_MS (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .restart     (restart),
        .difficulty  (difficulty),
        .mode_down   (mode_down),
        .auto_reload (auto_reload),
        .end_value   (end_value),
        .timer_value (timer_value),
        .end_reached (end_reached),
        .end_pulse   (end_pulse),
        .running     (running)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitor: every observed end_pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (!reset && end_pulse) begin
            if (prev_pulse) check_val("pulse_back_to_back", 1, 0);
            if (exp_q.size() == 0) check_val("pulse_unexpected", cyc, 0);
            else check_val("pulse_cycle", cyc, exp_q.pop_front());
        end
        prev_pulse = end_pulse;
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_run(input logic dn, input logic ar, input logic [1:0] diff,
                             input logic [11:0] ev, output int e);
        mode_down   = dn;
        auto_reload = ar;
        difficulty  = diff;
        end_value   = ev;
        enable      = 1'b1;
        restart     = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_value"},   timer_value, 0);
        check_val({tag, "_reached"}, end_reached, 0);
        check_val({tag, "_pulse"},   end_pulse,   0);
        check_val({tag, "_running"}, running,     0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset = 1'b1; enable = 1'b0; restart = 1'b0; difficulty = 2'd0;
        mode_down = 1'b0; auto_reload = 1'b0; end_value = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // IDLE ignores enable alone
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_running", running, 0);
        check_val("idle_value", timer_value, 0);

        // Up, 1x, end 100: terminal after 1000 cycles, then holds
        start_run(1'b0, 1'b0, 2'd0, 12'd100, e);
        exp_q.push_back(e + 1000);
        check_val("up_running", running, 1);
        end_value = 12'd7; mode_down = 1'b1;   // ignored until restart
        wait_to(e + 999);
        check_val("up_pre_term", timer_value, 99);
        check_val("up_pre_reached", end_reached, 0);
        wait_to(e + 1000);
        check_val("up_term", timer_value, 100);
        check_val("up_reached", end_reached, 1);
        check_val("up_done_running", running, 0);
        wait_to(e + 1200);
        check_val("up_hold", timer_value, 100);

        // 2x and 3x speeds
        start_run(1'b0, 1'b0, 2'd1, 12'd100, e);
        exp_q.push_back(e + 500);
        wait_to(e + 500);
        check_val("x2_term", timer_value, 100);
        check_val("x2_reached", end_reached, 1);
        start_run(1'b0, 1'b0, 2'd2, 12'd100, e);
        exp_q.push_back(e + 300);
        wait_to(e + 299);
        check_val("x3_pre", timer_value, 99);
        wait_to(e + 300);
        check_val("x3_term", timer_value, 100);

        // Down with auto-reload, end 20
        start_run(1'b1, 1'b1, 2'd0, 12'd20, e);
        exp_q.push_back(e + 200);
        exp_q.push_back(e + 410);
        exp_q.push_back(e + 620);
        check_val("down_load", timer_value, 20);
        mode_down = 1'b0; auto_reload = 1'b0; end_value = 12'd5;
        wait_to(e + 200);
        check_val("down_zero", timer_value, 0);
        wait_to(e + 210);
        check_val("down_reload", timer_value, 20);
        wait_to(e + 620);
        check_val("down_lap3", timer_value, 0);
        check_val("down_reached", end_reached, 0);
        check_val("down_running", running, 1);

        // Pause for 37 cycles mid-run
        start_run(1'b0, 1'b0, 2'd0, 12'd50, e);
        exp_q.push_back(e + 537);
        wait_to(e + 99);
        enable = 1'b0;
        wait_to(e + 120);
        check_val("pause_running", running, 0);
        wait_to(e + 136);
        enable = 1'b1;
        wait_to(e + 536);
        check_val("pause_pre", timer_value, 49);
        wait_to(e + 537);
        check_val("pause_term", timer_value, 50);
        check_val("pause_reached", end_reached, 1);

        // end_value = 0: terminal on the first cycle after restart
        start_run(1'b0, 1'b0, 2'd0, 12'd0, e);
        exp_q.push_back(e + 1);
        wait_to(e + 1);
        check_val("zero_reached", end_reached, 1);
        check_val("zero_value", timer_value, 0);
        repeat (5) @(negedge clk);

        // restart and reset together: reset wins
        restart = 1'b1; reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_restart");
        restart = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_restart_idle", running, 0);

        // Reset mid-run at timer_value 50
        start_run(1'b0, 1'b0, 2'd0, 12'd100, e);
        wait_to(e + 500);
        check_val("midrun_value", timer_value, 50);
        #5 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        repeat (30) @(negedge clk);
        check_val("post_reset_running", running, 0);
        check_val("post_reset_value", timer_value, 0);

        check_val("pulses_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
